// File: rtl/dm_pkg.sv
// Shared definitions for the parametrised data memory: access-size encodings,
// the clear/serve FSM state type and small lane helpers.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dm_state_t;

  // Byte-enable mask for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True for accesses the trapping build must reject.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load-lane extract: picks the addressed byte or halfword out of a 32-bit
// word and sign- or zero-extends it. Word accesses pass through unchanged.
// Also intended for the cache fill path, so it stays purely combinational.
module dm_lane_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_sel = word_i[7:0];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_param.sv
// Parametrised data memory: DEPTH x 32-bit array with byte/half/word access,
// registered load result with a Valid strobe, and a reset-driven sequencer
// that zeroes the whole array before requests are served.
//
// Build option: DM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses and the reserved size are
//               rejected (no write, Valid+Err, Dout=0).
//   undefined - Err stays 0, half/word addresses are silently realigned and
//               the reserved size behaves as a word access.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | zeroing Ram[ptr] one word per cycle; Busy=1, requests dropped
// IDLE  | serving load/store requests
module dm_param
  import dm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       din_i,
  output logic [31:0]       dout_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  dm_state_t        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [31:0]      ram_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             accept;
  logic [1:0]       eff_size;
  logic [1:0]       eff_lane;
  logic             reject;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;

  logic [31:0]      dout_q;
  logic             valid_q;
  logic             err_q;

  // Upper address bits are ignored so accesses wrap modulo DEPTH*4.
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];
  end

  // FSM state and clear pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: walk the pointer through the array once, then serve forever.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == CLEAR);
  assign accept = req_i && (state_q == IDLE);
  assign idx    = addr_i[IDX_W+1:2];

  // Access decode: effective size/lane and rejection of illegal accesses.
  always_comb begin
    eff_size = size_i;
    eff_lane = addr_i[1:0];
    reject   = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    reject   = misaligned(size_i, addr_i[1:0]);
`else
    if (size_i == SZ_RSVD) begin
      eff_size = SZ_WORD;
    end
    if (eff_size == SZ_HALF) begin
      eff_lane[0] = 1'b0;
    end else if (eff_size == SZ_WORD) begin
      eff_lane = 2'b00;
    end
`endif
  end

  // Store lane merge: replicate the right-aligned data across lanes and let
  // the byte enables pick the addressed ones.
  always_comb begin
    st_be = lane_mask(eff_size, eff_lane);
    case (eff_size)
      SZ_BYTE: st_data = {4{din_i[7:0]}};
      SZ_HALF: st_data = {2{din_i[15:0]}};
      default: st_data = din_i;
    endcase
  end

  // Array write port, shared between the clear sequencer and stores.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = idx;
    ram_be    = st_be;
    ram_wdata = st_data;
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        ram_we    = 1'b1;
        ram_addr  = ptr_q;
        ram_be    = 4'hF;
        ram_wdata = '0;
      end else if (accept && we_i && !reject) begin
        ram_we = 1'b1;
      end
    end
  end

  // Byte-enabled array write.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          ram_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = ram_q[idx];

  dm_lane_ext u_lane_ext (
    .word_i     (rd_word),
    .lane_i     (eff_lane),
    .size_i     (eff_size),
    .unsigned_i (unsigned_i),
    .data_o     (ld_data)
  );

  // Output registers: one-cycle Valid/Err pulses, Dout held between requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      err_q   <= accept && reject;
      if (accept) begin
        dout_q <= (we_i || reject) ? 32'h0 : ld_data;
      end
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param at DEPTH=16: reset/clear timing, a table of load/store
// vectors scored through a queue, and hand-written reset corner sequences.
module tb_dm_param;
  import dm_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              valid;
  logic              busy;
  logic              err;

  dm_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .din_i      (din),
    .dout_o     (dout),
    .valid_o    (valid),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic addv(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.we = w; v.size = s; v.uns = u; v.addr = a; v.din = d; v.exp_dout = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Scoreboard monitor: every Valid pops one expectation.
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid actual=1 expected=0 dout=%h", dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_dout", dout, e.dout);
        chk("sb_err", {31'b0, err}, {31'b0, e.err});
      end
    end else if (err === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL err_without_valid actual=1 expected=0");
    end
  end

  // Called at the negedge where Rst has just been released; drives dropped
  // requests while Busy is high and returns the number of busy cycles.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) begin
        req = 1'b0;
        break;
      end
      n++;
      req = 1'b1; we = i[0]; size = SZ_WORD; addr = 32'h8; din = 32'hFFFF_FFFF;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    exp_t e;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = '0; din = '0;

    // Vector table: memory is all zero after the clear.
    addv(0, SZ_WORD, 0, 32'h3C, 32'h0,         32'h0000_0000, 0);
    addv(1, SZ_WORD, 0, 32'h08, 32'hDEADBEEF,  32'h0000_0000, 0);
    addv(0, SZ_BYTE, 0, 32'h0B, 32'h0,         32'hFFFF_FFDE, 0);
    addv(0, SZ_BYTE, 1, 32'h0B, 32'h0,         32'h0000_00DE, 0);
    addv(0, SZ_HALF, 0, 32'h0A, 32'h0,         32'hFFFF_DEAD, 0);
    addv(0, SZ_HALF, 1, 32'h08, 32'h0,         32'h0000_BEEF, 0);
    addv(1, SZ_BYTE, 0, 32'h09, 32'hFFFF_FF12, 32'h0000_0000, 0);
    addv(0, SZ_WORD, 0, 32'h08, 32'h0,         32'hDEAD_12EF, 0);
    addv(1, SZ_WORD, 0, 32'h40, 32'h1111_1111, 32'h0000_0000, 0);
    addv(0, SZ_WORD, 0, 32'h00, 32'h0,         32'h1111_1111, 0);
    addv(1, SZ_HALF, 0, 32'h12, 32'hFFFF_ABCD, 32'h0000_0000, 0);
    addv(0, SZ_WORD, 0, 32'h10, 32'h0,         32'hABCD_0000, 0);
    addv(0, SZ_HALF, 0, 32'h12, 32'h0,         32'hFFFF_ABCD, 0);
    addv(1, SZ_WORD, 0, 32'h04, 32'h80C0_7F01, 32'h0000_0000, 0);
`ifdef DM_MISALIGN_TRAP_EN
    addv(0, SZ_HALF, 0, 32'h05, 32'h0,         32'h0000_0000, 1);
    addv(1, SZ_WORD, 0, 32'h06, 32'hCAFE_F00D, 32'h0000_0000, 1);
    addv(0, SZ_WORD, 0, 32'h04, 32'h0,         32'h80C0_7F01, 0);
    addv(0, SZ_BYTE, 1, 32'h07, 32'h0,         32'h0000_0080, 0);
    addv(0, SZ_RSVD, 0, 32'h00, 32'h0,         32'h0000_0000, 1);
    addv(1, SZ_RSVD, 0, 32'h00, 32'h0000_0055, 32'h0000_0000, 1);
    addv(0, SZ_WORD, 1, 32'h00, 32'h0,         32'h1111_1111, 0);
    addv(0, SZ_BYTE, 0, 32'h40, 32'h0,         32'h0000_0011, 0);
`else
    addv(0, SZ_HALF, 0, 32'h05, 32'h0,         32'h0000_7F01, 0);
    addv(1, SZ_WORD, 0, 32'h06, 32'hCAFE_F00D, 32'h0000_0000, 0);
    addv(0, SZ_WORD, 0, 32'h04, 32'h0,         32'hCAFE_F00D, 0);
    addv(0, SZ_BYTE, 1, 32'h07, 32'h0,         32'h0000_00CA, 0);
    addv(0, SZ_RSVD, 0, 32'h00, 32'h0,         32'h1111_1111, 0);
    addv(1, SZ_RSVD, 0, 32'h00, 32'h0000_0055, 32'h0000_0000, 0);
    addv(0, SZ_WORD, 1, 32'h00, 32'h0,         32'h0000_0055, 0);
    addv(0, SZ_BYTE, 0, 32'h40, 32'h0,         32'h0000_0055, 0);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_dout", dout, 32'h0);
    rst = 1'b0;
    count_busy(n);
    chk("clear_cycles", n, DEPTH);

    // Table vectors, back to back, starting in the first cycle with Busy=0.
    foreach (vecs[i]) begin
      req = 1'b1; we = vecs[i].we; size = vecs[i].size; uns = vecs[i].uns;
      addr = vecs[i].addr; din = vecs[i].din;
      e.dout = vecs[i].exp_dout; e.err = vecs[i].exp_err;
      sb.push_back(e);
      @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'b0, valid}, 32'd0);
    chk("hold_dout", dout, vecs[vecs.size()-1].exp_dout);

    // Reset together with an accepted load: request cancelled, Dout cleared.
    req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h8; rst = 1'b1;
    @(negedge clk);
    chk("rstreq_valid", {31'b0, valid}, 32'd0);
    chk("rstreq_dout", dout, 32'h0);
    chk("rstreq_busy", {31'b0, busy}, 32'd1);
    req = 1'b0; rst = 1'b0;

    // Reset again once the clear pointer has reached 7.
    repeat (7) @(negedge clk);
    chk("midclear_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("restart_cycles", n, DEPTH);

    // The clear must have wiped earlier contents.
    req = 1'b1; we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h8;
    e.dout = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; addr = 32'h4;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_pending", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
